reg_bus_master: RTL
===================

Name: reg_bus_master

Overview:
- Initiator side of the 4-phase req/ack register-bank interface used by the SD register block.
- Accepts single read/write commands from a local client and drives rw/addr/data_in/req to the register bank.
- Returns read data or an error after the handshake completes or times out.
- Sits between the SD host control logic and the register bank, replacing the bench stimulus driver in the integrated design.

Parameters:
- data_width, 32, width of register data in both directions.
- addr_width, 5, width of register address.
- timeout_cycles, 16, maximum cycles spent waiting in each handshake phase before abort (must be ≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets on the next clk edge).
- cmd_valid  input  1  client command present.
- cmd_ready  output  1  master can accept a command (high only in IDLE).
- cmd_rw  input  1  1=write, 0=read.
- cmd_addr  input  addr_width  target register address.
- cmd_wdata  input  data_width  write data (ignored for reads).
- rsp_valid  output  1  one-cycle pulse: transaction finished.
- rsp_rdata  output  data_width  captured read data; holds until next read completes.
- rsp_err  output  1  valid with rsp_valid; 1 = timeout occurred.
- busy  output  1  high whenever state ≠ IDLE.
- req  output  1  handshake request to register bank.
- ack  input  1  handshake acknowledge from register bank.
- rw  output  1  bus direction, 1=write, 0=read.
- addr  output  addr_width  bus address.
- data_in  output  data_width  write data to register bank.
- data_out  input  data_width  read data from register bank, valid while ack=1.

Behaviour:
- Reset (reset=0 at clk edge) forces:
  - state=IDLE; req=0, rw=0, addr=0, data_in=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, timer=0.
  - cmd_ready=1 after reset releases.
  - Reset mid-transaction aborts immediately with no rsp_valid; req drops on that edge.
- States: IDLE, REQ, RELEASE; registered outputs; cmd_ready = (state==IDLE).
- IDLE:
  - Accept on cmd_valid & cmd_ready at edge N.
  - Latch rw/addr/data_in (data_in=0 for reads); req=1; timer=0; go REQ.
  - req is therefore high from cycle N+1.
- REQ:
  - rw/addr/data_in held stable.
  - ack=1 sampled: req<=0; on a read, rsp_rdata<=data_out; err_flag<=0; go RELEASE.
  - ack=0 and timer==timeout_cycles-1: req<=0; err_flag<=1; go RELEASE.
  - Otherwise timer++.
  - Timer resets to 0 on entry to RELEASE.
- RELEASE (wait for ack low):
  - ack=0 sampled: rsp_valid<=1 for exactly one cycle; rsp_err<=err_flag; go IDLE.
  - ack still 1 and timer==timeout_cycles-1: rsp_valid<=1; rsp_err<=1; go IDLE.
  - Otherwise timer++.
- Bus signals rw/addr/data_in hold their last value in IDLE; only req qualifies them.
- On a timed-out read, rsp_rdata is not updated.
- rsp_err=0 whenever rsp_valid=0.
- Minimum latency, with a bank that acks one cycle after req and drops one cycle after req falls:
  - accept edge N; req high N+1; ack high N+2; req low N+3; ack low N+4; rsp_valid high during N+5.
- An ack already high when entering REQ is honoured in the first REQ cycle.
- A new command can be accepted in the cycle rsp_valid is high, since the state is IDLE.
- Counter width is clog2(timeout_cycles); no wrap occurs because the timer is cleared at the limit.

Test Plan:
- Write: cmd_rw=1, cmd_addr=5'h03, cmd_wdata=32'hDEADBEEF, bank acks after 1 cycle -> req high with rw=1, addr=3, data_in=DEADBEEF stable until ack; single rsp_valid pulse, rsp_err=0; read-back returns DEADBEEF.
- Read: cmd_rw=0, addr=5'h1F, bank presents data_out=32'h0000A5A5 with ack after 3 cycles -> rsp_rdata=0000A5A5, rsp_err=0; cmd_ready low throughout busy.
- Timeout: ack tied 0, timeout_cycles=16 -> req drops after 16 REQ cycles; rsp_valid with rsp_err=1; rsp_rdata unchanged from previous read.
- Stuck ack: ack held 1 after first assertion -> RELEASE times out after 16 cycles; rsp_valid with rsp_err=1; returns to IDLE with cmd_ready=1.
- Reset mid-op: reset=0 while in REQ -> next edge req=0, busy=0, no rsp_valid; the next command completes normally.
- Back-to-back: cmd_valid held high with two commands (write addr 1 = 32'h1, then read addr 1) -> second accepted in the rsp_valid cycle of the first; read returns 32'h00000001.

Source files
------------

// File: rtl/reg_bus_master.sv
// Initiator for the 4-phase req/ack register-bank handshake: takes one client
// command at a time, runs the bus handshake with per-phase timeouts, reports result.
module reg_bus_master #(
  parameter int data_width     = 32,
  parameter int addr_width     = 5,
  parameter int timeout_cycles = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  req,
  input  logic                  ack,
  output logic                  rw,
  output logic [addr_width-1:0] addr,
  output logic [data_width-1:0] data_in,
  input  logic [data_width-1:0] data_out
);

  localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                state_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic                  err_flag_q;
  logic                  req_q;
  logic                  rw_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] data_in_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [data_width-1:0] rsp_rdata_q;

  // The timer is cleared whenever it reaches T_LAST, so it never wraps.
  assign timer_d = timer_q + TW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      err_flag_q  <= 1'b0;
      req_q       <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            rw_q      <= cmd_rw;
            addr_q    <= cmd_addr;
            data_in_q <= cmd_rw ? cmd_wdata : '0;
            req_q     <= 1'b1;
            timer_q   <= '0;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack that is already high on entry is accepted right away.
          if (ack) begin
            req_q      <= 1'b0;
            err_flag_q <= 1'b0;
            if (!rw_q) begin
              rsp_rdata_q <= data_out;
            end
            timer_q <= '0;
            state_q <= S_RELEASE;
          end else if (timer_q == T_LAST) begin
            req_q      <= 1'b0;
            err_flag_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= S_RELEASE;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_RELEASE: begin
          if (!ack) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_flag_q;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else if (timer_q == T_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          req_q   <= 1'b0;
          timer_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign req       = req_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
